// File: rtl/mux_word_serializer_pkg.sv
// Shared types and helpers for the word serializer and its select mux.
package mux_word_serializer_pkg;

  // The select mux is a fixed 32:1, so the word width is pinned here.
  localparam int unsigned WordW = 32;
  localparam int unsigned SelW  = $clog2(WordW);

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

  // First bit index of a word for the chosen bit order.
  function automatic logic [SelW-1:0] start_idx(input bit msb_first);
    return msb_first ? SelW'(WordW - 1) : '0;
  endfunction

  // Final bit index of a word for the chosen bit order.
  function automatic logic [SelW-1:0] end_idx(input bit msb_first);
    return msb_first ? '0 : SelW'(WordW - 1);
  endfunction

  // Next bit index; callers never step past end_idx.
  function automatic logic [SelW-1:0] step_idx(input logic [SelW-1:0] idx,
                                               input bit msb_first);
    return msb_first ? idx - 1'b1 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/mux_32x1.sv
// 32-to-1 single-bit multiplexer: y = a[sel].
module mux_32x1 (
  input  logic [31:0] a,
  input  logic [4:0]  sel,
  output logic        y
);

  // Pure selection, no state.
  always_comb begin
    y = a[sel];
  end

endmodule

// File: rtl/mux_word_serializer.sv
// Parallel-in / serial-out stage: captures a word over valid/ready and walks the
// 32:1 mux select through every bit index, one bit per accepted output beat.
module mux_word_serializer
  import mux_word_serializer_pkg::*;
#(
  parameter int unsigned K         = WordW,
  parameter int unsigned SELW      = $clog2(K),
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [K-1:0]    in_data,
  input  logic            out_ready,
  output logic            ser_valid,
  output logic            ser_bit,
  output logic            ser_last,
  output logic [SELW-1:0] sel_dbg
);

  localparam logic [SELW-1:0] StartIdx = start_idx(MSB_FIRST);
  localparam logic [SELW-1:0] EndIdx   = end_idx(MSB_FIRST);

  state_e          state_q, state_d;
  logic [SELW-1:0] cnt_q, cnt_d;
  logic [K-1:0]    hold_q, hold_d;
  logic            at_end;

  assign at_end = (state_q == StShift) && (cnt_q == EndIdx);

  // Outputs depend only on registers, except in_ready which also sees rst/out_ready.
  always_comb begin
    ser_valid = (state_q == StShift);
    ser_last  = at_end;
    sel_dbg   = cnt_q;
    in_ready  = !rst && ((state_q == StIdle) || (at_end && out_ready));
  end

  // Next-state: capture, step, reload back-to-back, or drain to idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          hold_d  = in_data;
          cnt_d   = StartIdx;
          state_d = StShift;
        end
      end
      StShift: begin
        if (out_ready) begin
          if (!at_end) begin
            cnt_d = step_idx(cnt_q, MSB_FIRST);
          end else if (in_valid) begin
            // Reload on the final beat so consecutive words have no bubble.
            hold_d = in_data;
            cnt_d  = StartIdx;
          end else begin
            cnt_d   = StartIdx;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset drops any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= StartIdx;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  mux_32x1 u_mux (
    .a   (hold_q),
    .sel (cnt_q),
    .y   (ser_bit)
  );

endmodule

// File: tb/tb_mux_word_serializer.sv
// Directed bench: an LSB-first and an MSB-first instance run in lockstep on
// shared inputs; each sequence checks the instance matching its bit order.
module tb_mux_word_serializer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready_l, ser_valid_l, ser_bit_l, ser_last_l;
  logic [4:0]  sel_dbg_l;
  logic        in_ready_m, ser_valid_m, ser_bit_m, ser_last_m;
  logic [4:0]  sel_dbg_m;

  int n_checks = 0;
  int n_fail   = 0;

  mux_word_serializer #(.K(32), .SELW(5), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_l),
    .in_data   (in_data),
    .out_ready (out_ready),
    .ser_valid (ser_valid_l),
    .ser_bit   (ser_bit_l),
    .ser_last  (ser_last_l),
    .sel_dbg   (sel_dbg_l)
  );

  mux_word_serializer #(.K(32), .SELW(5), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_m),
    .in_data   (in_data),
    .out_ready (out_ready),
    .ser_valid (ser_valid_m),
    .ser_bit   (ser_bit_m),
    .ser_last  (ser_last_m),
    .sel_dbg   (sel_dbg_m)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] word;
    bit          msb;
    logic        first_bit;
    logic        last_bit;
    int          pop;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word in IDLE and clock it in.
  task automatic accept(input logic [31:0] word, input bit msb);
    check("idle_in_ready", msb ? in_ready_m : in_ready_l, 1);
    in_valid  = 1'b1;
    in_data   = word;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    in_data   = 32'hDEAD_BEEF;
  endtask

  // Check one output beat (beat number b of the word), then clock it out.
  task automatic beat(input logic [31:0] word, input bit msb, input int b,
                      inout logic [31:0] got);
    int idx;
    idx = msb ? 31 - b : b;
    check($sformatf("valid_b%0d", b), msb ? ser_valid_m : ser_valid_l, 1);
    check($sformatf("sel_b%0d", b), msb ? sel_dbg_m : sel_dbg_l, idx);
    check($sformatf("bit_b%0d", b), msb ? ser_bit_m : ser_bit_l, word[idx]);
    check($sformatf("last_b%0d", b), msb ? ser_last_m : ser_last_l, (b == 31) ? 1 : 0);
    got[b] = msb ? ser_bit_m : ser_bit_l;
    tick();
  endtask

  task automatic check_idle(input string name, input bit msb);
    check({name, "_valid"}, msb ? ser_valid_m : ser_valid_l, 0);
    check({name, "_last"}, msb ? ser_last_m : ser_last_l, 0);
    check({name, "_in_ready"}, msb ? in_ready_m : in_ready_l, 1);
  endtask

  initial begin
    logic [31:0] got;
    int          pop;

    vecs[0] = '{32'h8000_0001, 1'b0, 1'b1, 1'b1, 2};
    vecs[1] = '{32'hC000_0000, 1'b1, 1'b1, 1'b0, 2};
    vecs[2] = '{32'h0000_FFFF, 1'b0, 1'b1, 1'b0, 16};
    vecs[3] = '{32'h0000_FFFF, 1'b1, 1'b0, 1'b1, 16};
    vecs[4] = '{32'hA5A5_A5A5, 1'b1, 1'b1, 1'b1, 16};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    #1;
    // Reset state
    check("rst_in_ready_l", in_ready_l, 0);
    check("rst_in_ready_m", in_ready_m, 0);
    check("rst_valid_l", ser_valid_l, 0);
    check("rst_last_l", ser_last_l, 0);
    check("rst_bit_l", ser_bit_l, 0);
    check("rst_sel_l", sel_dbg_l, 0);
    check("rst_sel_m", sel_dbg_m, 31);
    tick();
    rst = 1'b0;
    #1;
    check_idle("post_rst_l", 1'b0);
    check_idle("post_rst_m", 1'b1);

    // Table: full words in either bit order, out_ready held high
    for (int v = 0; v < 5; v++) begin
      got = '0;
      accept(vecs[v].word, vecs[v].msb);
      for (int b = 0; b < 32; b++) beat(vecs[v].word, vecs[v].msb, b, got);
      check_idle($sformatf("v%0d_after", v), vecs[v].msb);
      pop = 0;
      for (int i = 0; i < 32; i++) pop += int'(got[i]);
      check($sformatf("v%0d_first", v), got[0], vecs[v].first_bit);
      check($sformatf("v%0d_lastbit", v), got[31], vecs[v].last_bit);
      check($sformatf("v%0d_pop", v), pop, vecs[v].pop);
    end

    // Backpressure: stall 3 cycles at beat 5 (bit 4 of A5A5A5A5 is 0)
    got = '0;
    accept(32'hA5A5_A5A5, 1'b0);
    for (int b = 0; b < 32; b++) begin
      if (b == 4) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          check($sformatf("stall%0d_bit", s), ser_bit_l, 0);
          check($sformatf("stall%0d_sel", s), sel_dbg_l, 4);
          check($sformatf("stall%0d_valid", s), ser_valid_l, 1);
          check($sformatf("stall%0d_in_ready", s), in_ready_l, 0);
          tick();
        end
        out_ready = 1'b1;
      end
      beat(32'hA5A5_A5A5, 1'b0, b, got);
    end
    check("stall_word", got, 32'hA5A5_A5A5);
    check_idle("stall_after", 1'b0);

    // Back-to-back: in_valid held high, second word taken on final beat
    accept(32'h0000_FFFF, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'hFFFF_0000;
    got = '0;
    for (int b = 0; b < 32; b++) begin
      check($sformatf("b2b_in_ready_b%0d", b), in_ready_l, (b == 31) ? 1 : 0);
      beat(32'h0000_FFFF, 1'b0, b, got);
    end
    in_valid = 1'b0;
    check("b2b_word1", got, 32'h0000_FFFF);
    got = '0;
    for (int b = 0; b < 32; b++) beat(32'hFFFF_0000, 1'b0, b, got);
    check("b2b_word2", got, 32'hFFFF_0000);
    check_idle("b2b_after", 1'b0);

    // Busy ignore: a zero word offered at beat 3 is not captured
    got = '0;
    accept(32'hFFFF_FFFF, 1'b0);
    for (int b = 0; b < 32; b++) begin
      if (b == 2) begin
        in_valid = 1'b1;
        in_data  = 32'h0000_0000;
        #1;
        check("busy_in_ready", in_ready_l, 0);
      end
      beat(32'hFFFF_FFFF, 1'b0, b, got);
      in_valid = 1'b0;
    end
    check("busy_word", got, 32'hFFFF_FFFF);
    check_idle("busy_after", 1'b0);

    // Reset mid-word at beat 10, asserted between edges
    got = '0;
    accept(32'hFFFF_FFFF, 1'b0);
    for (int b = 0; b < 9; b++) beat(32'hFFFF_FFFF, 1'b0, b, got);
    check("prerst_valid", ser_valid_l, 1);
    check("prerst_sel", sel_dbg_l, 9);
    rst = 1'b1;
    #1;
    check("midrst_valid_l", ser_valid_l, 0);
    check("midrst_in_ready_l", in_ready_l, 0);
    check("midrst_valid_m", ser_valid_m, 0);
    check("midrst_bit_l", ser_bit_l, 0);
    check("midrst_sel_l", sel_dbg_l, 0);
    check("midrst_sel_m", sel_dbg_m, 31);
    tick();
    check("midrst_hold_in_ready", in_ready_l, 0);
    rst = 1'b0;
    #1;
    check_idle("relrst_l", 1'b0);
    got = '0;
    accept(32'h0000_0003, 1'b0);
    for (int b = 0; b < 32; b++) beat(32'h0000_0003, 1'b0, b, got);
    check("relrst_word", got, 32'h0000_0003);
    check_idle("relrst_after", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
